// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//   Multi-cycle controller around an 8-bit logical right barrel shifter.
//   A request (operand + total shift amount) is taken over a valid/ready
//   handshake. The block then issues barrel passes of at most STEP_MAX bits
//   until the full amount has been applied. The result is offered over a
//   second valid/ready handshake. The barrel (ym, k -> q) is modelled
//   internally, and this block is its only driver.
//
// Parameters
//   AMT_W     width of the requested shift amount
//   STEP_MAX  largest shift issued in one barrel pass (1..7)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   request present
//   in_ready   out  request can be taken this cycle (IDLE and not in reset)
//   in_data    in   8-bit operand
//   in_amt     in   total logical-right shift amount
//   out_valid  out  result present (DONE)
//   out_ready  in   consumer takes the result this cycle
//   out_data   out  in_data >> in_amt, zero-filled (0 outside DONE)
//   busy       out  high in SHIFT or DONE
// ---------------------------------------------------------------------------
module shift_sequencer #(
    parameter int AMT_W    = 5,
    parameter int STEP_MAX = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [2:0]       STEP_K   = 3'(STEP_MAX);
    localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP_MAX);

    logic [1:0]       state_q, state_d;
    logic [7:0]       acc_q, acc_d;
    logic [AMT_W-1:0] rem_q, rem_d;

    logic [7:0]       ym_s;
    logic [2:0]       k_s;
    logic [7:0]       q_s;
    logic [AMT_W-1:0] rem_left_s;
    logic             accept_s;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= 8'h00;
            rem_q   <= {AMT_W{1'b0}};
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
        end
    end

    // Barrel drive: k = min(rem, STEP_MAX) only while shifting, else 0.
    always_comb begin
        ym_s = acc_q;
        k_s  = 3'd0;
        case (state_q)
            ST_SHIFT: begin
                if (rem_q > STEP_AMT) begin
                    k_s = STEP_K;
                end else begin
                    k_s = 3'(rem_q);
                end
            end
            default: begin
                k_s = 3'd0;
            end
        endcase
    end

    // The shared barrel shifter itself: zero-filled logical right shift.
    always_comb begin
        q_s = ym_s >> k_s;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = ST_IDLE;
        acc_d      = acc_q;
        rem_d      = rem_q;
        // k never exceeds rem, so this cannot wrap.
        rem_left_s = rem_q - AMT_W'(k_s);
        accept_s   = in_valid & in_ready;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    acc_d = in_data;
                    rem_d = in_amt;
                    if (in_amt == {AMT_W{1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_d = q_s;
                rem_d = rem_left_s;
                if (rem_left_s == {AMT_W{1'b0}}) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                // No acceptance here: the earliest new request is taken in IDLE.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the state register (in_ready also masked by reset).
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = ~rst;
            end
            ST_SHIFT: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                out_data  = acc_q;
                busy      = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [4:0] in_amt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    int errors;
    int checks;

    shift_sequencer #(.AMT_W(5), .STEP_MAX(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request until the next rising edge, then scramble the inputs.
    task automatic send_req(input logic [7:0] d, input logic [4:0] a);
        in_data  = d;
        in_amt   = a;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
        in_amt   = 5'd31;
    endtask

    // Edges after the acceptance edge until out_valid is seen; -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    // Take the result with a one-cycle out_ready pulse.
    task automatic consume;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00; in_amt = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_amt0;
        int lat;
        send_req(8'hB5, 5'd0);
        wait_valid(lat);
        checks++; if (lat !== 0) begin errors++; $display("FAIL amt0_latency: got %0d expected 0", lat); end
        checks++; if (out_data !== 8'hB5) begin errors++; $display("FAIL amt0_data: got %h expected b5", out_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL amt0_busy: got %b expected 1", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL amt0_in_ready: got %b expected 0", in_ready); end
        consume();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL amt0_consumed: out_valid got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL amt0_idle: in_ready got %b expected 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL amt0_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_passes;
        logic [7:0] d   [6] = '{8'hFF, 8'h80, 8'hA0, 8'hC3, 8'hFF, 8'hFF};
        logic [4:0] a   [6] = '{5'd3,  5'd7,  5'd5,  5'd9,  5'd31, 5'd14};
        logic [7:0] exp [6] = '{8'h1F, 8'h01, 8'h05, 8'h00, 8'h00, 8'h00};
        int         el  [6] = '{1, 1, 1, 2, 5, 2};
        int lat;
        for (int i = 0; i < 6; i++) begin
            send_req(d[i], a[i]);
            wait_valid(lat);
            checks++; if (lat !== el[i]) begin errors++; $display("FAIL pass_latency[%0d]: got %0d expected %0d", i, lat, el[i]); end
            checks++; if (out_data !== exp[i]) begin errors++; $display("FAIL pass_data[%0d]: got %h expected %h", i, out_data, exp[i]); end
            consume();
        end
    endtask

    task automatic test_backpressure;
        int lat;
        send_req(8'hF0, 5'd4);
        wait_valid(lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL bp_latency: got %0d expected 1", lat); end
        in_data = 8'h33; in_amt = 5'd1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_data !== 8'h0F) begin errors++; $display("FAIL bp_data[%0d]: got %h expected 0f", i, out_data); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_released: out_valid got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_same_cycle_accept: in_ready got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_data = 8'h00; in_amt = 5'd0;
        wait_valid(lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL bp_second_latency: got %0d expected 1", lat); end
        checks++; if (out_data !== 8'h19) begin errors++; $display("FAIL bp_second_data: got %h expected 19", out_data); end
        consume();
    endtask

    task automatic test_reset_mid;
        int lat;
        logic seen;
        send_req(8'hFF, 5'd20);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready: got %b expected 0", in_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_rst_busy_before: got %b expected 1", busy); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy_after: got %b expected 0", busy); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_idle: in_ready got %b expected 1", in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_rst_dropped: out_valid seen %b expected 0", seen); end
        send_req(8'h0F, 5'd2);
        wait_valid(lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL post_rst_latency: got %0d expected 1", lat); end
        checks++; if (out_data !== 8'h03) begin errors++; $display("FAIL post_rst_data: got %h expected 03", out_data); end
        consume();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_amt0();
        test_passes();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
